// File: rtl/hv_lv_pwm_intb_pkg.sv
// Shared definitions for the HV-side pwm_intb encoder and the LV-side decoder.
// Both sides import this package so that pulse counts and the decoder's
// width windows stay consistent across the isolation channel.
package hv_lv_pwm_intb_pkg;

  // Encoder frame FSM states.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PULSE_LO = 2'd1,
    ST_PULSE_HI = 2'd2,
    ST_GUARD    = 2'd3
  } pwm_intb_state_e;

  // Pulses per frame: 1 pulse = interrupt asserted, 4 pulses = released.
  localparam int ASSERT_PULSE_NUM   = 1;
  localparam int DEASSERT_PULSE_NUM = 4;

  // Decoder low-pulse acceptance window, exclusive bounds (valid widths 5..7
  // from the encoder's side, decoder tolerates 4..8).
  localparam int DN_TH = 4;
  localparam int UP_TH = 8;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/hv_pwm_intb_encode.sv
// HV-side transmitter for the shared pwm_intb_n line. Turns the HV interrupt
// level into low-pulse frames: ASSERT_PULSE_NUM pulses for intb_n=0 and
// DEASSERT_PULSE_NUM pulses for intb_n=1, each frame closed by a high guard.
//
// Ports:
//   i_clk            clock
//   i_rst_n          asynchronous active-low reset
//   i_hv_intb_n      HV interrupt level (0 = interrupt), synchronous to i_clk
//   i_enc_en         encoder enable; gates the start of new frames only
//   o_hv_pwm_intb_n  encoded line, registered, idle high
//   o_busy           1 while a frame (pulses or guard) is in progress
//   o_sent_intb_n    last level completely transmitted
module hv_pwm_intb_encode
  import hv_lv_pwm_intb_pkg::*;
#(
  parameter int PULSE_LO_CYC       = 6,
  parameter int PULSE_HI_CYC       = 6,
  parameter int GUARD_CYC          = 16,
  parameter int ASSERT_PULSE_NUM   = hv_lv_pwm_intb_pkg::ASSERT_PULSE_NUM,
  parameter int DEASSERT_PULSE_NUM = hv_lv_pwm_intb_pkg::DEASSERT_PULSE_NUM
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_hv_intb_n,
  input  logic i_enc_en,
  output logic o_hv_pwm_intb_n,
  output logic o_busy,
  output logic o_sent_intb_n
);

  localparam int MAX_CYC = max3(PULSE_LO_CYC, PULSE_HI_CYC, GUARD_CYC);
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] LO_LOAD = CNT_W'(PULSE_LO_CYC - 1);
  localparam logic [CNT_W-1:0] HI_LOAD = CNT_W'(PULSE_HI_CYC - 1);
  localparam logic [CNT_W-1:0] GD_LOAD = CNT_W'(GUARD_CYC - 1);
  localparam logic [2:0]       AS_NUM  = 3'(ASSERT_PULSE_NUM);
  localparam logic [2:0]       DE_NUM  = 3'(DEASSERT_PULSE_NUM);

  // Keep the encoder inside the decoder's acceptance windows.
  if (PULSE_LO_CYC <= DN_TH || PULSE_LO_CYC >= UP_TH) begin : g_chk_lo
    $error("PULSE_LO_CYC must lie strictly between DN_TH and UP_TH");
  end
  if (PULSE_HI_CYC < 1 || PULSE_HI_CYC > UP_TH) begin : g_chk_hi
    $error("PULSE_HI_CYC must be in 1..UP_TH");
  end
  if (GUARD_CYC < 12) begin : g_chk_gd
    $error("GUARD_CYC must be at least 12");
  end
  if (ASSERT_PULSE_NUM < 1 || ASSERT_PULSE_NUM > 7 ||
      DEASSERT_PULSE_NUM < 1 || DEASSERT_PULSE_NUM > 7) begin : g_chk_num
    $error("pulse counts must fit the 3-bit pulse counter (1..7)");
  end

  pwm_intb_state_e  r_state, w_nxt_state;
  logic [CNT_W-1:0] r_cnt, w_nxt_cnt;
  logic [2:0]       r_pulse_rem, w_nxt_pulse_rem;
  logic             r_tgt, w_nxt_tgt;
  logic             r_line, w_nxt_line;
  logic             r_sent, w_nxt_sent;
  logic             r_busy;

  // Width counter is loaded with (length-1) on every state change and counts
  // down to zero; the transition happens on the cycle it reads zero.
  always_comb begin
    w_nxt_state     = r_state;
    w_nxt_cnt       = r_cnt;
    w_nxt_pulse_rem = r_pulse_rem;
    w_nxt_tgt       = r_tgt;
    w_nxt_line      = 1'b1;
    w_nxt_sent      = r_sent;
    unique case (r_state)
      ST_IDLE: begin
        // Only the level present here matters; edges seen mid-frame are not
        // remembered, so a glitch that returns to the sent level is dropped.
        if (i_enc_en && (i_hv_intb_n != r_sent)) begin
          w_nxt_tgt       = i_hv_intb_n;
          w_nxt_pulse_rem = i_hv_intb_n ? DE_NUM : AS_NUM;
          w_nxt_state     = ST_PULSE_LO;
          w_nxt_cnt       = LO_LOAD;
          w_nxt_line      = 1'b0;
        end
      end
      ST_PULSE_LO: begin
        w_nxt_line = 1'b0;
        if (r_cnt == '0) begin
          w_nxt_pulse_rem = r_pulse_rem - 3'd1;
          w_nxt_line      = 1'b1;
          if (r_pulse_rem > 3'd1) begin
            w_nxt_state = ST_PULSE_HI;
            w_nxt_cnt   = HI_LOAD;
          end else begin
            w_nxt_state = ST_GUARD;
            w_nxt_cnt   = GD_LOAD;
            w_nxt_sent  = r_tgt;
          end
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      ST_PULSE_HI: begin
        if (r_cnt == '0) begin
          w_nxt_state = ST_PULSE_LO;
          w_nxt_cnt   = LO_LOAD;
          w_nxt_line  = 1'b0;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      ST_GUARD: begin
        if (r_cnt == '0) begin
          w_nxt_state = ST_IDLE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt - 1'b1;
        end
      end
      default: begin
        w_nxt_state = ST_IDLE;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_pulse_rem <= '0;
      r_tgt       <= 1'b1;
      r_line      <= 1'b1;
      r_sent      <= 1'b1;
      r_busy      <= 1'b0;
    end else begin
      r_state     <= w_nxt_state;
      r_cnt       <= w_nxt_cnt;
      r_pulse_rem <= w_nxt_pulse_rem;
      r_tgt       <= w_nxt_tgt;
      r_line      <= w_nxt_line;
      r_sent      <= w_nxt_sent;
      r_busy      <= (w_nxt_state != ST_IDLE);
    end
  end

  assign o_hv_pwm_intb_n = r_line;
  assign o_busy          = r_busy;
  assign o_sent_intb_n   = r_sent;

endmodule

// File: tb/tb_hv_pwm_intb_encode.sv
// Directed bench for hv_pwm_intb_encode with default parameters. A table of
// segments {hv, en, cycles, expected line/busy/sent} is replayed; every cycle
// of every segment is compared. Reset handling is exercised by hand.
module tb_hv_pwm_intb_encode;

  typedef struct {
    logic hv;
    logic en;
    int   n;
    logic line;
    logic busy;
    logic sent;
  } seg_t;

  logic i_clk = 1'b0;
  logic i_rst_n;
  logic i_hv_intb_n;
  logic i_enc_en;
  logic o_hv_pwm_intb_n;
  logic o_busy;
  logic o_sent_intb_n;

  int n_pass = 0;
  int n_tot  = 0;
  seg_t segs[$];

  hv_pwm_intb_encode dut (
    .i_clk           (i_clk),
    .i_rst_n         (i_rst_n),
    .i_hv_intb_n     (i_hv_intb_n),
    .i_enc_en        (i_enc_en),
    .o_hv_pwm_intb_n (o_hv_pwm_intb_n),
    .o_busy          (o_busy),
    .o_sent_intb_n   (o_sent_intb_n)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string name, input logic [2:0] want);
    logic [2:0] got;
    got = {o_hv_pwm_intb_n, o_busy, o_sent_intb_n};
    n_tot++;
    if (got === want) n_pass++;
    else $display("FAIL %s line/busy/sent got=%b want=%b", name, got, want);
  endtask

  task automatic add(input logic hv, input logic en, input int n,
                     input logic line, input logic busy, input logic sent);
    seg_t s;
    s.hv = hv; s.en = en; s.n = n; s.line = line; s.busy = busy; s.sent = sent;
    segs.push_back(s);
  endtask

  // Release frame body with sent_intb_n = sent_before during the pulses.
  task automatic add_release(input logic en, input logic sent_before);
    for (int p = 0; p < 4; p++) begin
      add(1'b1, en, 6, 1'b0, 1'b1, sent_before);
      if (p < 3) add(1'b1, en, 6, 1'b1, 1'b1, sent_before);
    end
    add(1'b1, en, 16, 1'b1, 1'b1, 1'b1);
  endtask

  initial begin
    i_rst_n     = 1'b0;
    i_hv_intb_n = 1'b1;
    i_enc_en    = 1'b1;

    // Idle, no mismatch.
    add(1, 1, 100, 1, 0, 1);
    // Assert frame: 6 low, 16 guard, sent falls on guard entry.
    add(0, 1, 6, 0, 1, 1);
    add(0, 1, 16, 1, 1, 0);
    add(0, 1, 5, 1, 0, 0);
    // Release frame: 4 pulses, 3 gaps, guard.
    add_release(1, 0);
    add(1, 1, 5, 1, 0, 1);
    // 1->0 then 0->1 mid-pulse: assert completes, release follows after guard.
    add(0, 1, 3, 0, 1, 1);
    add(1, 1, 3, 0, 1, 1);
    add(1, 1, 16, 1, 1, 0);
    add(1, 1, 1, 1, 0, 0);
    add_release(1, 0);
    add(1, 1, 3, 1, 0, 1);
    // 0->1->0 inside an assert frame: no second frame.
    add(0, 1, 2, 0, 1, 1);
    add(1, 1, 2, 0, 1, 1);
    add(0, 1, 2, 0, 1, 1);
    add(0, 1, 16, 1, 1, 0);
    add(0, 1, 10, 1, 0, 0);
    // Enable dropped mid release frame: frame still completes, then holds.
    add(1, 1, 2, 0, 1, 0);
    add(1, 0, 4, 0, 1, 0);
    for (int p = 0; p < 3; p++) begin
      add(1, 0, 6, 1, 1, 0);
      add(1, 0, 6, 0, 1, 0);
    end
    add(1, 0, 16, 1, 1, 1);
    add(1, 0, 5, 1, 0, 1);
    // Mismatch while disabled: nothing sent; enable starts frame next edge.
    add(0, 0, 10, 1, 0, 1);
    add(0, 1, 6, 0, 1, 1);
    add(0, 1, 16, 1, 1, 0);
    add(0, 1, 3, 1, 0, 0);

    repeat (3) @(negedge i_clk);
    chk("reset_state", 3'b101);
    i_rst_n = 1'b1;

    foreach (segs[k]) begin
      i_hv_intb_n = segs[k].hv;
      i_enc_en    = segs[k].en;
      for (int c = 0; c < segs[k].n; c++) begin
        @(posedge i_clk);
        @(negedge i_clk);
        chk($sformatf("seg%0d_cyc%0d", k, c),
            {segs[k].line, segs[k].busy, segs[k].sent});
      end
    end

    // Reset during pulse 2 of a release frame (state here: sent=0, hv=0).
    i_hv_intb_n = 1'b1;
    repeat (14) @(negedge i_clk);
    chk("pulse2_low", 3'b010);
    #1 i_rst_n = 1'b0;
    #1 chk("reset_mid_frame", 3'b101);
    repeat (2) @(negedge i_clk);
    i_rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      @(negedge i_clk);
      chk($sformatf("post_reset_idle%0d", c), 3'b101);
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
